pick_drop_controller: RTL and testbench
=======================================

Name: pick_drop_controller

Overview:
- Parametrised successor to the single-onion pick/drop logic. Tracks NUM_ONIONS onion objects, one plate and one multi-onion pot with a cook timer.
- Decodes E (pick/drop) and Q (chop) actions against the tile in front of the penguin.
- Drives per-object coordinates and states for the sprite drawers.
- Issues write commands to the external counter-contents tracker.

Parameters:
NUM_ONIONS, 4, number of onion objects (1..8)
COORD_W, 10, coordinate width
DEBOUNCE, 3, frames key must be released before the next action fires
CHOP_HITS, 5, Q actions needed to chop an onion
POT_CAP, 3, chopped onions needed to start cooking
COOK_FRAMES, 120, frames from start of cooking to ready
HOLD_OFF, 20, held-sprite offset added to penguin X and Y
SCORE_W, 4, score width

Ports:
frame_clk  in  1  frame clock; all state updates on rising edge
Reset  in  1  asynchronous, active-low reset; state clears while Reset=0
keycode  in  8  08h=E, 14h=Q, other=none
wallFlag  in  1  penguin touching a wall
penguinX, penguinY  in  COORD_W each  penguin position
nearestCounterX, nearestCounterY  in  COORD_W each  facing tile origin
tileType  in  4  0 board, 1 counter, 2 crate, 3 stove, 6 trash, 8 vent
cellKind  in  2  tracker contents of facing tile: 0 empty, 2 plate, 3 onion
cellOnionId  in  3  onion index when cellKind=3
cellWrEn  out  1  one-cycle tracker write strobe
cellWrKind  out  2  kind to write
cellWrId  out  3  onion id to write
heldKind  out  2  0 none, 2 plate, 3 onion
heldId  out  3  index of held onion
onionX, onionY  out  NUM_ONIONS*COORD_W each  packed; onion i at bits [i*COORD_W +: COORD_W]
onionState  out  NUM_ONIONS*2  0 inactive, 1 raw, 2 chopped
chopCount  out  3  chop progress of the onion on the facing board
plateX, plateY  out  COORD_W each  plate position
plateState  out  1  0 empty, 1 full
potCount  out  3  onions in the pot
potState  out  2  0 filling, 1 cooking, 2 ready
score  out  SCORE_W  delivered orders

Behaviour:
- Reset values: all outputs 0, except:
  - plateX=220, plateY=220.
  - onion coordinates 0.
  - internal release counter = DEBOUNCE, so the first press fires.
- Action gate: an action fires on the first frame keycode=08h/14h while release counter ≥ DEBOUNCE; the counter then clears. Keycode not 08h/14h increments the counter, saturating at DEBOUNCE. Holding a key fires exactly once.
- cellWrEn pulses the frame after a fire when the tracker changes; otherwise 0.
- E with wallFlag=1:
  - Held none:
    - cellKind=2: pick up plate; write kind 0.
    - cellKind=3: pick up onion cellOnionId; write kind 0; chopCount clears.
    - Else tileType=2: spawn the lowest inactive onion as raw and hold it. If none are inactive, no action.
  - Held onion:
    - tileType 1 or 0 with cellKind=0: place it at the counter coordinates; write kind 3 with its id; heldKind→0.
    - tileType 6: onion→inactive, held none.
    - tileType 3: only if chopped, potState=0 and potCount<POT_CAP. Onion→inactive and potCount+1. When potCount reaches POT_CAP, potState→1 and the cook timer loads.
  - Held plate:
    - Counter with cellKind=0: place it; write kind 2.
    - Stove with potState=2 and plateState=0: plateState→1, potCount→0, potState→0.
    - Vent: if plateState=1, score+1 (saturates at max). Plate→(20,260), plateState→0, held none, write kind 2.
- E with wallFlag=0: no action.
- Q: only fires when tileType=0, cellKind=3 and that onion is raw. chopCount+1; on reaching CHOP_HITS the onion→chopped and chopCount→0. chopCount also clears whenever cellOnionId changes.
- Cook timer: decrements every frame while potState=1. At 0, potState→2. Unaffected by keys.
- Every frame (including action frames), the held object's coordinates = penguin + HOLD_OFF.
- Asserting Reset mid-cook or while holding returns everything to reset values immediately.

Test Plan:
- Reset, then E at crate (tileType=2, wallFlag=1) with penguin (100,100) -> onion0 raw, heldKind=3, heldId=0, onion0 at (120,120) next frame.
- Hold E for 10 frames at crate, then release 3 frames and press again -> one spawn on the first press, onion1 spawned on the second.
- Place onion on board (cellKind=0, tileType=0); Q ×5 with 4-frame gaps -> chopCount 1..4 then 0, onion0 state=2; a sixth Q -> no change.
- Add three chopped onions to the stove (POT_CAP=3) -> potState=1. After 120 frames potState=2. E holding empty plate at stove -> plateState=1, potCount=0.
- Full plate to vent -> score increments, plate at (20,260), cellWrEn pulse with kind 2. Score at 15 plus another delivery -> stays 15.
- All 4 onions active, E at crate -> no spawn. Reset low mid-cook -> all outputs at reset values while low.

Source files
------------

// File: rtl/pick_drop_controller.sv
// Pick/drop controller: decodes E/Q actions against the facing tile and
// tracks onions, one plate and a cooking pot for the sprite drawers.
module pick_drop_controller #(
  parameter int NUM_ONIONS  = 4,
  parameter int COORD_W     = 10,
  parameter int DEBOUNCE    = 3,
  parameter int CHOP_HITS   = 5,
  parameter int POT_CAP     = 3,
  parameter int COOK_FRAMES = 120,
  parameter int HOLD_OFF    = 20,
  parameter int SCORE_W     = 4
) (
  input  logic                          frame_clk,
  input  logic                          Reset,
  input  logic [7:0]                    keycode,
  input  logic                          wallFlag,
  input  logic [COORD_W-1:0]            penguinX,
  input  logic [COORD_W-1:0]            penguinY,
  input  logic [COORD_W-1:0]            nearestCounterX,
  input  logic [COORD_W-1:0]            nearestCounterY,
  input  logic [3:0]                    tileType,
  input  logic [1:0]                    cellKind,
  input  logic [2:0]                    cellOnionId,
  output logic                          cellWrEn,
  output logic [1:0]                    cellWrKind,
  output logic [2:0]                    cellWrId,
  output logic [1:0]                    heldKind,
  output logic [2:0]                    heldId,
  output logic [NUM_ONIONS*COORD_W-1:0] onionX,
  output logic [NUM_ONIONS*COORD_W-1:0] onionY,
  output logic [NUM_ONIONS*2-1:0]       onionState,
  output logic [2:0]                    chopCount,
  output logic [COORD_W-1:0]            plateX,
  output logic [COORD_W-1:0]            plateY,
  output logic                          plateState,
  output logic [2:0]                    potCount,
  output logic [1:0]                    potState,
  output logic [SCORE_W-1:0]            score
);

  localparam int RW = $clog2(DEBOUNCE + 1);
  localparam int TW = $clog2(COOK_FRAMES + 1);
  localparam logic [1:0] O_OFF  = 2'd0;
  localparam logic [1:0] O_RAW  = 2'd1;
  localparam logic [1:0] O_CHOP = 2'd2;

  typedef enum logic [1:0] {
    H_NONE  = 2'd0,
    H_PLATE = 2'd2,
    H_ONION = 2'd3
  } held_e;

  typedef enum logic [1:0] {
    POT_FILL  = 2'd0,
    POT_COOK  = 2'd1,
    POT_READY = 2'd2
  } pot_e;

  held_e               r_held;
  pot_e                r_pot;
  logic [RW-1:0]       r_rel;
  logic [TW-1:0]       r_timer;
  logic [2:0]          r_last;
  logic [COORD_W-1:0]  r_ox [8];
  logic [COORD_W-1:0]  r_oy [8];
  logic [1:0]          r_os [8];

  logic                w_isE;
  logic                w_isQ;
  logic                w_ready;
  logic                w_fire;
  logic                w_cid_ok;
  logic                w_free_ok;
  logic [2:0]          w_free_id;
  logic [2:0]          w_chop_base;
  logic [COORD_W-1:0]  w_hx;
  logic [COORD_W-1:0]  w_hy;

  assign w_isE       = keycode == 8'h08;
  assign w_isQ       = keycode == 8'h14;
  assign w_ready     = r_rel >= RW'(DEBOUNCE);
  assign w_fire      = (w_isE || w_isQ) && w_ready;
  assign w_cid_ok    = 32'(cellOnionId) < NUM_ONIONS;
  assign w_chop_base = (cellOnionId != r_last) ? 3'd0 : chopCount;
  assign w_hx        = penguinX + COORD_W'(HOLD_OFF);
  assign w_hy        = penguinY + COORD_W'(HOLD_OFF);
  assign heldKind    = r_held;
  assign potState    = r_pot;

  for (genvar g = 0; g < NUM_ONIONS; g++) begin : g_out
    assign onionX[g*COORD_W +: COORD_W] = r_ox[g];
    assign onionY[g*COORD_W +: COORD_W] = r_oy[g];
    assign onionState[g*2 +: 2]         = r_os[g];
  end

  // lowest-numbered inactive onion is the next one a crate hands out
  always_comb begin
    w_free_ok = 1'b0;
    w_free_id = '0;
    for (int i = NUM_ONIONS - 1; i >= 0; i--) begin
      if (r_os[i] == O_OFF) begin
        w_free_ok = 1'b1;
        w_free_id = 3'(i);
      end
    end
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      r_held     <= H_NONE;
      r_pot      <= POT_FILL;
      r_rel      <= RW'(DEBOUNCE);
      r_timer    <= '0;
      r_last     <= '0;
      for (int i = 0; i < 8; i++) begin
        r_ox[i] <= '0;
        r_oy[i] <= '0;
        r_os[i] <= O_OFF;
      end
      cellWrEn   <= 1'b0;
      cellWrKind <= '0;
      cellWrId   <= '0;
      heldId     <= '0;
      chopCount  <= '0;
      plateX     <= COORD_W'(220);
      plateY     <= COORD_W'(220);
      plateState <= 1'b0;
      potCount   <= '0;
      score      <= '0;
    end else begin
      cellWrEn <= 1'b0;
      r_last   <= cellOnionId;
      if (cellOnionId != r_last) chopCount <= '0;

      if (w_fire) r_rel <= '0;
      else if (!w_isE && !w_isQ && !w_ready) r_rel <= r_rel + 1'b1;

      if (r_pot == POT_COOK) begin
        r_timer <= r_timer - 1'b1;
        if (r_timer == TW'(1)) r_pot <= POT_READY;
      end

      // held sprite follows the penguin; action branches below override
      unique case (r_held)
        H_ONION: begin
          r_ox[heldId] <= w_hx;
          r_oy[heldId] <= w_hy;
        end
        H_PLATE: begin
          plateX <= w_hx;
          plateY <= w_hy;
        end
        default: ;
      endcase

      if (w_fire && w_isQ && tileType == 4'd0 && cellKind == 2'd3 &&
          w_cid_ok && r_os[cellOnionId] == O_RAW) begin
        if (w_chop_base == 3'(CHOP_HITS - 1)) begin
          r_os[cellOnionId] <= O_CHOP;
          chopCount         <= '0;
        end else begin
          chopCount <= w_chop_base + 3'd1;
        end
      end

      if (w_fire && w_isE && wallFlag) begin
        unique case (r_held)
          H_NONE: begin
            if (cellKind == 2'd2) begin
              r_held     <= H_PLATE;
              plateX     <= w_hx;
              plateY     <= w_hy;
              cellWrEn   <= 1'b1;
              cellWrKind <= 2'd0;
              cellWrId   <= '0;
            end else if (cellKind == 2'd3) begin
              r_held            <= H_ONION;
              heldId            <= cellOnionId;
              r_ox[cellOnionId] <= w_hx;
              r_oy[cellOnionId] <= w_hy;
              chopCount         <= '0;
              cellWrEn          <= 1'b1;
              cellWrKind        <= 2'd0;
              cellWrId          <= '0;
            end else if (tileType == 4'd2 && w_free_ok) begin
              r_os[w_free_id] <= O_RAW;
              r_ox[w_free_id] <= w_hx;
              r_oy[w_free_id] <= w_hy;
              r_held          <= H_ONION;
              heldId          <= w_free_id;
            end
          end
          H_ONION: begin
            if ((tileType == 4'd0 || tileType == 4'd1) && cellKind == 2'd0) begin
              r_ox[heldId] <= nearestCounterX;
              r_oy[heldId] <= nearestCounterY;
              r_held       <= H_NONE;
              cellWrEn     <= 1'b1;
              cellWrKind   <= 2'd3;
              cellWrId     <= heldId;
            end else if (tileType == 4'd6) begin
              r_os[heldId] <= O_OFF;
              r_ox[heldId] <= r_ox[heldId];
              r_oy[heldId] <= r_oy[heldId];
              r_held       <= H_NONE;
            end else if (tileType == 4'd3 && r_os[heldId] == O_CHOP &&
                         r_pot == POT_FILL && potCount < 3'(POT_CAP)) begin
              r_os[heldId] <= O_OFF;
              r_ox[heldId] <= r_ox[heldId];
              r_oy[heldId] <= r_oy[heldId];
              r_held       <= H_NONE;
              potCount     <= potCount + 3'd1;
              if (potCount == 3'(POT_CAP - 1)) begin
                r_pot   <= POT_COOK;
                r_timer <= TW'(COOK_FRAMES);
              end
            end
          end
          H_PLATE: begin
            if (tileType == 4'd1 && cellKind == 2'd0) begin
              plateX     <= nearestCounterX;
              plateY     <= nearestCounterY;
              r_held     <= H_NONE;
              cellWrEn   <= 1'b1;
              cellWrKind <= 2'd2;
              cellWrId   <= '0;
            end else if (tileType == 4'd3 && r_pot == POT_READY && !plateState) begin
              plateState <= 1'b1;
              potCount   <= '0;
              r_pot      <= POT_FILL;
            end else if (tileType == 4'd8) begin
              if (plateState && score != '1) score <= score + 1'b1;
              plateX     <= COORD_W'(20);
              plateY     <= COORD_W'(260);
              plateState <= 1'b0;
              r_held     <= H_NONE;
              cellWrEn   <= 1'b1;
              cellWrKind <= 2'd2;
              cellWrId   <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pick_drop_controller.sv
// Bench for pick_drop_controller: directed kitchen scenarios plus random
// frames, all checked against a frame-level behavioural model.
module tb_pick_drop_controller;

  localparam int N = 4, CW = 10, DEB = 3, CHOP = 5, CAP = 3;
  localparam int COOK = 120, HOFF = 20, SW = 4;
  localparam logic [7:0] KE = 8'h08, KQ = 8'h14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] key = '0;
  logic wall = 1'b0;
  logic [CW-1:0] px = '0, py = '0, ncx = '0, ncy = '0;
  logic [3:0] tt = '0;
  logic [1:0] ck = '0;
  logic [2:0] cid = '0;

  logic wr_en;
  logic [1:0] wr_kind, held_k, pot_s;
  logic [2:0] wr_id, held_i, chop_c, pot_c;
  logic [N*CW-1:0] o_x, o_y;
  logic [N*2-1:0] o_s;
  logic [CW-1:0] pl_x, pl_y;
  logic pl_s;
  logic [SW-1:0] sc;

  int n_chk = 0, n_fail = 0;

  int m_rel, m_held, m_hid, m_chop, m_last;
  int m_ox[8], m_oy[8], m_os[8];
  int m_plx, m_ply, m_pls, m_potc, m_pot, m_timer, m_score;
  int m_wr, m_wk, m_wi;

  pick_drop_controller dut (
    .frame_clk(clk), .Reset(rst_n), .keycode(key), .wallFlag(wall),
    .penguinX(px), .penguinY(py),
    .nearestCounterX(ncx), .nearestCounterY(ncy),
    .tileType(tt), .cellKind(ck), .cellOnionId(cid),
    .cellWrEn(wr_en), .cellWrKind(wr_kind), .cellWrId(wr_id),
    .heldKind(held_k), .heldId(held_i),
    .onionX(o_x), .onionY(o_y), .onionState(o_s),
    .chopCount(chop_c), .plateX(pl_x), .plateY(pl_y),
    .plateState(pl_s), .potCount(pot_c), .potState(pot_s), .score(sc)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_rel = DEB; m_held = 0; m_hid = 0; m_chop = 0; m_last = 0;
    for (int i = 0; i < 8; i++) begin
      m_ox[i] = 0; m_oy[i] = 0; m_os[i] = 0;
    end
    m_plx = 220; m_ply = 220; m_pls = 0;
    m_potc = 0; m_pot = 0; m_timer = 0; m_score = 0;
    m_wr = 0; m_wk = 0; m_wi = 0;
  endtask

  task automatic mwrite(input int k, input int i);
    m_wr = 1; m_wk = k; m_wi = i;
  endtask

  // one frame of game rules applied to the inputs seen at the clock edge
  task automatic model_step();
    bit is_e, is_q, fire;
    int op, h, f;
    if (!rst_n) begin
      model_reset();
      return;
    end
    is_e = key == KE;
    is_q = key == KQ;
    fire = (is_e || is_q) && m_rel >= DEB;
    if (fire) m_rel = 0;
    else if (!is_e && !is_q && m_rel < DEB) m_rel++;
    m_wr = 0;
    if (int'(cid) != m_last) m_chop = 0;
    m_last = int'(cid);
    op = m_pot;
    if (op == 1) begin
      m_timer--;
      if (m_timer == 0) m_pot = 2;
    end
    if (fire && is_q && tt == 0 && ck == 3 && int'(cid) < N &&
        m_os[cid] == 1) begin
      m_chop++;
      if (m_chop == CHOP) begin
        m_os[cid] = 2;
        m_chop = 0;
      end
    end
    if (fire && is_e && wall) begin
      if (m_held == 0) begin
        if (ck == 2) begin
          m_held = 2; mwrite(0, 0);
        end else if (ck == 3) begin
          m_held = 3; m_hid = int'(cid); m_chop = 0; mwrite(0, 0);
        end else if (tt == 2) begin
          f = -1;
          for (int i = N - 1; i >= 0; i--) if (m_os[i] == 0) f = i;
          if (f >= 0) begin
            m_os[f] = 1; m_held = 3; m_hid = f;
          end
        end
      end else if (m_held == 3) begin
        h = m_hid;
        if ((tt == 0 || tt == 1) && ck == 0) begin
          m_ox[h] = int'(ncx); m_oy[h] = int'(ncy);
          m_held = 0; mwrite(3, h);
        end else if (tt == 6) begin
          m_os[h] = 0; m_held = 0;
        end else if (tt == 3 && m_os[h] == 2 && op == 0 && m_potc < CAP) begin
          m_os[h] = 0; m_held = 0; m_potc++;
          if (m_potc == CAP) begin
            m_pot = 1; m_timer = COOK;
          end
        end
      end else if (m_held == 2) begin
        if (tt == 1 && ck == 0) begin
          m_plx = int'(ncx); m_ply = int'(ncy); m_held = 0; mwrite(2, 0);
        end else if (tt == 3 && op == 2 && m_pls == 0) begin
          m_pls = 1; m_potc = 0; m_pot = 0;
        end else if (tt == 8) begin
          if (m_pls == 1 && m_score < (1 << SW) - 1) m_score++;
          m_plx = 20; m_ply = 260; m_pls = 0; m_held = 0; mwrite(2, 0);
        end
      end
    end
    if (m_held == 3) begin
      m_ox[m_hid] = (int'(px) + HOFF) % (1 << CW);
      m_oy[m_hid] = (int'(py) + HOFF) % (1 << CW);
    end else if (m_held == 2) begin
      m_plx = (int'(px) + HOFF) % (1 << CW);
      m_ply = (int'(py) + HOFF) % (1 << CW);
    end
  endtask

  task automatic compare_all();
    logic [N*CW-1:0] ex, ey;
    logic [2*N-1:0] es;
    for (int i = 0; i < N; i++) begin
      ex[i*CW +: CW] = CW'(m_ox[i]);
      ey[i*CW +: CW] = CW'(m_oy[i]);
      es[2*i +: 2] = 2'(m_os[i]);
    end
    check("held_kind", 64'(held_k), 64'(m_held));
    if (m_held == 3) check("held_id", 64'(held_i), 64'(m_hid));
    check("onion_state", 64'(o_s), 64'(es));
    check("onion_x", 64'(o_x), 64'(ex));
    check("onion_y", 64'(o_y), 64'(ey));
    check("chop_count", 64'(chop_c), 64'(m_chop));
    check("plate_x", 64'(pl_x), 64'(m_plx));
    check("plate_y", 64'(pl_y), 64'(m_ply));
    check("plate_state", 64'(pl_s), 64'(m_pls));
    check("pot_count", 64'(pot_c), 64'(m_potc));
    check("pot_state", 64'(pot_s), 64'(m_pot));
    check("score", 64'(sc), 64'(m_score));
    check("wr_en", 64'(wr_en), 64'(m_wr));
    check("wr_kind", 64'(wr_kind), 64'(m_wk));
    check("wr_id", 64'(wr_id), 64'(m_wi));
  endtask

  task automatic frame();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    key = 8'h00;
    repeat (n) frame();
  endtask

  task automatic press(input logic [7:0] k);
    key = k;
    frame();
    key = 8'h00;
  endtask

  task automatic tile(input int t, input int k, input int id);
    tt = 4'(t); ck = 2'(k); cid = 3'(id);
  endtask

  // spawn, place on board, chop, pick back up and drop into the pot
  task automatic cook_one();
    int id;
    tile(2, 0, 0); press(KE); idle(3);
    id = m_hid;
    tile(0, 0, 0); press(KE); idle(3);
    tile(0, 3, id);
    repeat (CHOP) begin
      press(KQ); idle(3);
    end
    press(KE); idle(3);
    tile(3, 0, 0); press(KE);
  endtask

  task automatic deliver();
    repeat (CAP) begin
      cook_one(); idle(3);
    end
    idle(COOK);
    tile(1, 2, 0); press(KE); idle(3);
    tile(3, 0, 0); press(KE); idle(3);
    tile(8, 0, 0); press(KE);
  endtask

  initial begin
    model_reset();
    repeat (2) frame();
    check("rst_held", 64'(held_k), 64'd0);
    check("rst_plate_x", 64'(pl_x), 64'd220);
    check("rst_plate_y", 64'(pl_y), 64'd220);
    check("rst_score", 64'(sc), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_onions", 64'(o_s), 64'd0);
    rst_n = 1'b1;
    px = 10'd100; py = 10'd100; ncx = 10'd64; ncy = 10'd32; wall = 1'b1;

    tile(2, 0, 0); press(KE);
    check("spawn_held", 64'(held_k), 64'd3);
    check("spawn_id", 64'(held_i), 64'd0);
    check("spawn_state", 64'(o_s), 64'h01);
    check("spawn_x", 64'(o_x[9:0]), 64'd120);
    check("spawn_y", 64'(o_y[9:0]), 64'd120);
    key = KE; repeat (9) frame();
    check("hold_once", 64'(o_s), 64'h01);
    idle(3);
    tile(0, 0, 0); press(KE);
    check("place_wr", 64'(wr_en), 64'd1);
    check("place_kind", 64'(wr_kind), 64'd3);
    check("place_x", 64'(o_x[9:0]), 64'd64);
    idle(3);
    tile(2, 0, 0); press(KE);
    check("spawn2_state", 64'(o_s), 64'h05);
    check("spawn2_id", 64'(held_i), 64'd1);
    idle(3);

    tile(0, 3, 0);
    for (int k = 1; k <= CHOP; k++) begin
      press(KQ);
      check("chop_step", 64'(chop_c), 64'((k == CHOP) ? 0 : k));
      idle(4);
    end
    check("chop_done", 64'(o_s), 64'h06);
    press(KQ);
    check("chop_extra", 64'(o_s), 64'h06);
    idle(4);

    tile(6, 0, 0); press(KE);
    check("trash", 64'(o_s), 64'h02);
    idle(3);
    tile(0, 3, 0); press(KE); idle(3);
    tile(3, 0, 0); press(KE);
    check("pot_one", 64'(pot_c), 64'd1);
    idle(3);
    cook_one(); idle(3);
    cook_one();
    check("pot_cooking", 64'(pot_s), 64'd1);
    check("pot_full", 64'(pot_c), 64'd3);
    idle(COOK - 1);
    check("cook_not_yet", 64'(pot_s), 64'd1);
    idle(1);
    check("cook_ready", 64'(pot_s), 64'd2);

    tile(1, 2, 0); press(KE);
    check("plate_pick", 64'(held_k), 64'd2);
    idle(3);
    tile(3, 0, 0); press(KE);
    check("plate_full", 64'(pl_s), 64'd1);
    check("pot_emptied", 64'(pot_c), 64'd0);
    idle(3);
    tile(8, 0, 0); press(KE);
    check("vent_score", 64'(sc), 64'd1);
    check("vent_x", 64'(pl_x), 64'd20);
    check("vent_y", 64'(pl_y), 64'd260);
    check("vent_wr", 64'(wr_en), 64'd1);
    check("vent_kind", 64'(wr_kind), 64'd2);
    idle(3);

    repeat (15) begin
      deliver(); idle(3);
    end
    check("score_sat", 64'(sc), 64'd15);
    tile(1, 2, 0); press(KE); idle(3);
    tile(8, 0, 0); press(KE);
    check("empty_vent", 64'(sc), 64'd15);
    idle(3);

    repeat (CAP) begin
      cook_one(); idle(3);
    end
    idle(30);
    tile(1, 2, 0); press(KE); idle(2);
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare_all();
    check("midrst_pot", 64'(pot_s), 64'd0);
    check("midrst_held", 64'(held_k), 64'd0);
    check("midrst_plate", 64'(pl_x), 64'd220);
    idle(3);
    rst_n = 1'b1;

    repeat (N) begin
      tile(2, 0, 0); press(KE); idle(3);
      tile(0, 0, 0); press(KE); idle(3);
    end
    tile(2, 0, 0); press(KE);
    check("no_spawn_held", 64'(held_k), 64'd0);
    check("no_spawn_state", 64'(o_s), 64'h55);
    idle(3);

    for (int n = 0; n < 2000; n++) begin
      int r;
      r = $urandom_range(0, 4);
      key = (r == 0) ? KE : (r == 1) ? KQ : (r == 2) ? 8'h33 : 8'h00;
      wall = ($urandom_range(0, 4) != 0);
      r = $urandom_range(0, 6);
      tt = (r == 4) ? 4'd6 : (r == 5) ? 4'd8 : (r == 6) ? 4'd4 : 4'(r);
      r = $urandom_range(0, 2);
      ck = (r == 0) ? 2'd0 : (r == 1) ? 2'd2 : 2'd3;
      cid = 3'($urandom_range(0, N - 1));
      px = CW'($urandom); py = CW'($urandom);
      ncx = CW'($urandom); ncy = CW'($urandom);
      rst_n = ($urandom_range(0, 399) != 0);
      frame();
    end
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
